// File: rtl/alu_lane_sequencer_pkg.sv
// Shared scalar ALU definitions: op codes, flag bit positions and the
// lane sequencer FSM state type.
package alu_lane_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_lane_sequencer_lane_select.sv
// Combinational extract of one lane of the packed A/B operand vectors.
module alu_seq_lane_select #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES + 1)
) (
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [IDX_W-1:0]       idx,
  output logic [WIDTH-1:0]       lane_a,
  output logic [WIDTH-1:0]       lane_b
);

  // An index past the last lane selects nothing and yields zero.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) begin
        lane_a = a[i*WIDTH +: WIDTH];
        lane_b = b[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu_lane_sequencer.sv
// Feeds one vector lane per cycle to a shared combinational scalar ALU and
// packs the lane results. Define ALU_SEQ_CMP_MASK_EN to build the CMP Z mask.
module alu_lane_sequencer
  import alu_lane_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int LEN_W = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [LANES*WIDTH-1:0] req_a,
  input  logic [LANES*WIDTH-1:0] req_b,
  output logic [2:0]             alu_op,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_y,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LANES*WIDTH-1:0] rsp_y,
  output logic [3:0]             rsp_flags,
  output logic [LANES-1:0]       rsp_mask,
  output logic                   busy
);

  seq_state_e             state_q, state_d;
  logic [2:0]             op_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       idx_q;
  logic [LANES*WIDTH-1:0] a_q, b_q;
  logic [LANES*WIDTH-1:0] y_q;
  logic [3:0]             flags_q;
  logic [LEN_W-1:0]       len_clamped;
  logic [WIDTH-1:0]       lane_a, lane_b;
  logic                   accept;
  logic                   last_lane;

  assign len_clamped = (req_len > LEN_W'(LANES)) ? LEN_W'(LANES) : req_len;
  assign accept      = req_valid && (state_q == IDLE);
  assign last_lane   = (idx_q == len_q - LEN_W'(1));

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;

  alu_seq_lane_select #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .IDX_W (LEN_W)
  ) u_lane_select (
    .a      (a_q),
    .b      (b_q),
    .idx    (idx_q),
    .lane_a (lane_a),
    .lane_b (lane_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = (len_clamped == '0) ? DONE : RUN;
      RUN:  if (last_lane) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (state_q == RUN) begin
      alu_op = op_q;
      alu_a  = lane_a;
      alu_b  = lane_b;
    end
  end

  // Results are cleared on accept, so lanes beyond len simply stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      len_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      len_q   <= len_clamped;
      idx_q   <= '0;
      a_q     <= req_a;
      b_q     <= req_b;
      y_q     <= '0;
      flags_q <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < LANES; i++) begin
        if ((idx_q == LEN_W'(i)) && (op_q != OP_CMP)) y_q[i*WIDTH +: WIDTH] <= alu_y;
      end
      flags_q <= alu_flags;
      idx_q   <= idx_q + LEN_W'(1);
    end
  end

`ifdef ALU_SEQ_CMP_MASK_EN
  logic [LANES-1:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= '0;
    end else if ((state_q == RUN) && (op_q == OP_CMP)) begin
      for (int i = 0; i < LANES; i++) begin
        if (idx_q == LEN_W'(i)) mask_q[i] <= alu_flags[FLAG_Z];
      end
    end
  end

  assign rsp_mask = mask_q;
`else
  assign rsp_mask = '0;
`endif

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Self-checking bench for alu_lane_sequencer: behavioural ALU, transaction-level
// reference model, per-cycle compare process, directed and random vectors.
module tb_alu_lane_sequencer;
  import alu_lane_sequencer_pkg::*;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int LEN_W = 3;

  logic                   clk, rst_n;
  logic                   req_valid, req_ready;
  logic [2:0]             req_op;
  logic [LEN_W-1:0]       req_len;
  logic [LANES*WIDTH-1:0] req_a, req_b;
  logic [2:0]             alu_op;
  logic [WIDTH-1:0]       alu_a, alu_b, alu_y;
  logic [3:0]             alu_flags;
  logic                   rsp_valid, rsp_ready;
  logic [LANES*WIDTH-1:0] rsp_y;
  logic [3:0]             rsp_flags;
  logic [LANES-1:0]       rsp_mask;
  logic                   busy;

  int n_vec = 0;
  int n_err = 0;

  alu_lane_sequencer #(.WIDTH(WIDTH), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_len(req_len),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .rsp_mask(rsp_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar ALU: returns {y[7:0], N, Z, C, V}; C is carry for ADD, borrow for SUB/CMP.
  function automatic logic [11:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [8:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin r = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_MOV: r = {1'b0, a};
      OP_XOR: r = {1'b0, a ^ b};
      OP_OR:  r = {1'b0, a | b};
      OP_SHR: r = {1'b0, a >> b[2:0]};
      OP_SHL: r = {1'b0, a << b[2:0]};
      default: begin r = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (r[7] != a[7]); end
    endcase
    return {r[7:0], r[7], (r[7:0] == 8'd0), r[8], v};
  endfunction

  always_comb {alu_y, alu_flags} = alu_fn(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  flags;
    logic [3:0]  mask;
  } rsp_t;

  function automatic int clamp_len(logic [LEN_W-1:0] l);
    return (int'(l) > LANES) ? LANES : int'(l);
  endfunction

  function automatic rsp_t expect_rsp(logic [2:0] op, int len, logic [31:0] a, logic [31:0] b);
    rsp_t       r;
    logic [11:0] o;
    r = '0;
    for (int i = 0; i < len; i++) begin
      o = alu_fn(op, a[i*8 +: 8], b[i*8 +: 8]);
      if (op != OP_CMP) r.y[i*8 +: 8] = o[11:4];
      else              r.mask[i] = o[2];
      r.flags = o[3:0];
    end
`ifndef ALU_SEQ_CMP_MASK_EN
    r.mask = '0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted vector takes len edges of lane work, then
  // waits in the response phase until rsp_ready is seen on an edge.
  bit          m_active;
  int          m_cnt, m_len;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  rsp_t        m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_len    <= clamp_len(req_len);
        m_op     <= req_op;
        m_a      <= req_a;
        m_b      <= req_b;
        m_exp    <= expect_rsp(req_op, clamp_len(req_len), req_a, req_b);
      end
    end else if (m_cnt == m_len) begin
      if (rsp_ready) m_active <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, !m_active);
      check("busy", busy, m_active);
      check("rsp_valid", rsp_valid, m_active && (m_cnt == m_len));
      if (m_active && (m_cnt < m_len)) begin
        check("alu_op", alu_op, m_op);
        check("alu_a", alu_a, m_a[m_cnt*8 +: 8]);
        check("alu_b", alu_b, m_b[m_cnt*8 +: 8]);
      end else begin
        check("alu_op_idle", alu_op, 3'd0);
        check("alu_a_idle", alu_a, 8'd0);
        check("alu_b_idle", alu_b, 8'd0);
      end
      if (m_active && (m_cnt == m_len)) begin
        check("rsp_y", rsp_y, m_exp.y);
        check("rsp_flags", rsp_flags, m_exp.flags);
        check("rsp_mask", rsp_mask, m_exp.mask);
      end
    end
  end

  logic [7:0] seq_a[$];
  logic [7:0] seq_b[$];

  task automatic drive_noise();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom);
    req_len   = LEN_W'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic run_vec(input logic [2:0] op, input logic [LEN_W-1:0] len,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit noise,
                         output int lat, output logic [31:0] y,
                         output logic [3:0] fl, output logic [3:0] mk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    req_a     = a;
    req_b     = b;
    seq_a.delete();
    seq_b.delete();
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      seq_a.push_back(alu_a);
      seq_b.push_back(alu_b);
      if (noise) drive_noise();
      @(negedge clk);
      lat++;
    end
    y  = rsp_y;
    fl = rsp_flags;
    mk = rsp_mask;
    req_valid = 1'b0;
    if (!rsp_valid) begin
      check("rsp_timeout", 1'b0, 1'b1);
      return;
    end
    repeat (hold) begin
      if (noise) drive_noise();
      @(negedge clk);
      check("hold_req_ready", req_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      check("hold_rsp_y", rsp_y, y);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_handshake_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] y;
    logic [3:0]  fl, mk;
    logic [2:0]  rop;
    logic [LEN_W-1:0] rlen;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_len = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_y", rsp_y, 32'h0);
    check("reset_alu_op", alu_op, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD, four lanes.
    run_vec(OP_ADD, 3'd4, 32'h04030201, 32'h281E140A, 0, 1'b0, lat, y, fl, mk);
    check("add_latency", lat, 4);
    check("add_y", y, 32'h2C21160B);
    check("add_flags", fl, 4'h0);

    // SUB, two lanes: lanes 2/3 stay zero, ALU sees (9,1),(9,2).
    run_vec(OP_SUB, 3'd2, 32'h09090909, 32'h04030201, 0, 1'b0, lat, y, fl, mk);
    check("sub_y", y, 32'h00000708);
    check("sub_seq_len", seq_a.size(), 2);
    if (seq_a.size() == 2) begin
      check("sub_seq0", {seq_a[0], seq_b[0]}, 16'h0901);
      check("sub_seq1", {seq_a[1], seq_b[1]}, 16'h0902);
    end

    // len 0: immediate response, nothing presented to the ALU.
    run_vec(OP_XOR, 3'd0, 32'hFFFFFFFF, 32'h12345678, 0, 1'b0, lat, y, fl, mk);
    check("len0_latency", lat, 0);
    check("len0_y", y, 32'h0);
    check("len0_flags", fl, 4'h0);

    // CMP: results suppressed, Z collected into the mask when built.
    run_vec(OP_CMP, 3'd4, 32'h08070605, 32'h00070005, 0, 1'b0, lat, y, fl, mk);
    check("cmp_y", y, 32'h0);
`ifdef ALU_SEQ_CMP_MASK_EN
    check("cmp_mask", mk, 4'b0101);
`else
    check("cmp_mask", mk, 4'b0000);
`endif

    // Backpressure: three DONE cycles with rsp_ready low.
    run_vec(OP_OR, 3'd3, 32'h00F0A001, 32'h000F0502, 3, 1'b0, lat, y, fl, mk);
    check("bp_y", y, 32'h00FFA503);

    // Reset in RUN with lane 2 on the ALU.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_len = 3'd4;
    req_a = 32'h04030201; req_b = 32'h281E140A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_alu_a", alu_a, 8'd3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_run_req_ready", req_ready, 1'b1);
    check("rst_run_busy", busy, 1'b0);
    check("rst_run_rsp_valid", rsp_valid, 1'b0);
    check("rst_run_rsp_y", rsp_y, 32'h0);
    check("rst_run_flags", rsp_flags, 4'h0);
    check("rst_run_mask", rsp_mask, 4'h0);
    check("rst_run_alu", {alu_op, alu_a, alu_b}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(OP_ADD, 3'd1, 32'h00000007, 32'h00000005, 0, 1'b0, lat, y, fl, mk);
    check("post_reset_latency", lat, 1);
    check("post_reset_y", y, 32'h0000000C);

    // Random vectors with backpressure and request noise while busy.
    for (int n = 0; n < 60; n++) begin
      rop  = 3'($urandom);
      rlen = LEN_W'($urandom);
      run_vec(rop, rlen, $urandom, $urandom, $urandom_range(0, 3), 1'b1, lat, y, fl, mk);
      check("rand_latency", lat, clamp_len(rlen));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
